// File: rtl/logic_alu_pipe.sv
// Bitwise logic unit: eight logic ops, accumulator operand mode, zero/parity flags.
// Latency: 2 cycles from the accept edge to OUT_VALID; 1 result/cycle when OUT_READY stays high.
// Backpressure: stages advance only when the stage ahead is empty or draining; 2 results held, then IN_READY=0.
module logic_alu_pipe #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       OP,
  input  logic             ACC_EN,
  input  logic             ACC_CLR,
  input  logic             IN_VALID,
  output logic             IN_READY,
  output logic [WIDTH-1:0] X,
  output logic             Z,
  output logic             P,
  output logic             OUT_VALID,
  input  logic             OUT_READY
);

  // Op encodings
  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_XOR  = 3'b010;
  localparam logic [2:0] OP_NAND = 3'b011;
  localparam logic [2:0] OP_NOR  = 3'b100;
  localparam logic [2:0] OP_XNOR = 3'b101;
  localparam logic [2:0] OP_NOTA = 3'b110;
  localparam logic [2:0] OP_PASS = 3'b111;

  // Pipeline state: stage 1 result, accumulator, stage valids
  logic             s1_valid;
  logic [WIDTH-1:0] s1_res;
  logic             s2_valid;
  logic [WIDTH-1:0] acc;

  // Combinational control and datapath
  logic             adv1;
  logic             adv2;
  logic             accept;
  logic [WIDTH-1:0] eff_a;
  logic [WIDTH-1:0] res;

  // Advance chain: a stage may load when it is empty or the stage after it moves on.
  // OUT_READY reaches IN_READY combinationally so a full pipe still streams.
  always_comb begin
    adv2   = !s2_valid || OUT_READY;
    adv1   = !s1_valid || adv2;
    accept = IN_VALID && adv1;
  end

  assign IN_READY  = adv1;
  assign OUT_VALID = s2_valid;

  // Operand select and logic op; acc is the previous accepted result, so
  // back-to-back accumulate ops chain without a bubble.
  always_comb begin
    eff_a = ACC_EN ? acc : A;
    res   = '0;
    case (OP)
      OP_AND:  res = eff_a & B;
      OP_OR:   res = eff_a | B;
      OP_XOR:  res = eff_a ^ B;
      OP_NAND: res = ~(eff_a & B);
      OP_NOR:  res = ~(eff_a | B);
      OP_XNOR: res = ~(eff_a ^ B);
      OP_NOTA: res = ~eff_a;
      OP_PASS: res = eff_a;
      default: res = '0;
    endcase
  end

  // Stage 1: capture the op result on accept; drop to empty when advancing without an accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_res   <= '0;
    end else if (adv1) begin
      s1_valid <= accept;
      if (accept) begin
        s1_res <= res;
      end
    end
  end

  // Accumulator: follows every accepted result; a clear in the same cycle wins,
  // while the accepted op itself has already used the pre-clear value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (ACC_CLR) begin
      acc <= '0;
    end else if (accept) begin
      acc <= res;
    end
  end

  // Stage 2: output register with flags; frozen while a result waits for OUT_READY.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      X        <= '0;
      Z        <= 1'b0;
      P        <= 1'b0;
    end else if (adv2) begin
      s2_valid <= s1_valid;
      X        <= s1_res;
      Z        <= (s1_res == '0);
      P        <= ^s1_res;
    end
  end

endmodule

// File: tb/tb_logic_alu_pipe.sv
// Scoreboard bench for logic_alu_pipe at WIDTH=6 and WIDTH=32.
// Directed vectors with hand-computed results; expected entries queued on accept, popped by monitors.
// Monitors compare whenever OUT_VALID and OUT_READY are both high at the falling edge.
module tb_logic_alu_pipe;

  typedef struct packed {
    logic [5:0] x;
    logic       z;
    logic       p;
  } exp6_t;

  typedef struct packed {
    logic [31:0] x;
    logic        z;
    logic        p;
  } exp32_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [5:0]  a6 = '0, b6 = '0, x6;
  logic [2:0]  op6 = '0;
  logic        en6 = 1'b0, clr6 = 1'b0, iv6 = 1'b0, ir6, z6, p6, ov6, or6 = 1'b1;

  logic [31:0] a32 = '0, b32 = '0, x32;
  logic [2:0]  op32 = '0;
  logic        iv32 = 1'b0, ir32, z32, p32, ov32;

  exp6_t  q6[$];
  exp32_t q32[$];

  int passed = 0;
  int total  = 0;
  int cyc    = 0;
  logic hist [0:4095];

  logic_alu_pipe #(.WIDTH(6)) dut6 (
    .clk(clk), .rst(rst), .A(a6), .B(b6), .OP(op6), .ACC_EN(en6), .ACC_CLR(clr6),
    .IN_VALID(iv6), .IN_READY(ir6), .X(x6), .Z(z6), .P(p6),
    .OUT_VALID(ov6), .OUT_READY(or6)
  );

  logic_alu_pipe #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .A(a32), .B(b32), .OP(op32), .ACC_EN(1'b0), .ACC_CLR(1'b0),
    .IN_VALID(iv32), .IN_READY(ir32), .X(x32), .Z(z32), .P(p32),
    .OUT_VALID(ov32), .OUT_READY(1'b1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, req);
  endtask

  // WIDTH=6 monitor: record OUT_VALID history and score consumed results
  always @(negedge clk) begin
    hist[cyc % 4096] = ov6;
    if (!rst && ov6 && or6) begin
      if (q6.size() == 0) begin
        chk("x6_unexpected_output", 64'(x6), 64'hDEAD);
      end else begin
        exp6_t e;
        e = q6.pop_front();
        chk("x6", 64'(x6), 64'(e.x));
        chk("z6", 64'(z6), 64'(e.z));
        chk("p6", 64'(p6), 64'(e.p));
      end
    end
  end

  // WIDTH=32 monitor
  always @(negedge clk) begin
    if (!rst && ov32) begin
      if (q32.size() == 0) begin
        chk("x32_unexpected_output", 64'(x32), 64'hDEAD);
      end else begin
        exp32_t e;
        e = q32.pop_front();
        chk("x32", 64'(x32), 64'(e.x));
        chk("z32", 64'(z32), 64'(e.z));
        chk("p32", 64'(p32), 64'(e.p));
      end
    end
  end

  // Present one transaction and keep IN_VALID high after its accept edge (back-to-back capable)
  task automatic send(input logic [5:0] a, input logic [5:0] b, input logic [2:0] op,
                      input logic en, input logic clr, input logic [5:0] ex,
                      input logic ez, input logic ep);
    int n;
    exp6_t e;
    a6 = a; b6 = b; op6 = op; en6 = en; clr6 = clr; iv6 = 1'b1;
    n = 0;
    @(negedge clk);
    while (!ir6 && n < 60) begin
      n++;
      @(negedge clk);
    end
    if (!ir6) begin
      chk("accept_timeout", 64'(ir6), 64'd1);
      iv6 = 1'b0;
      clr6 = 1'b0;
      return;
    end
    e.x = ex; e.z = ez; e.p = ep;
    q6.push_back(e);
    @(posedge clk);
    #1;
    clr6 = 1'b0;
  endtask

  task automatic send32(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                        input logic [31:0] ex, input logic ez, input logic ep);
    int n;
    exp32_t e;
    a32 = a; b32 = b; op32 = op; iv32 = 1'b1;
    n = 0;
    @(negedge clk);
    while (!ir32 && n < 60) begin
      n++;
      @(negedge clk);
    end
    if (!ir32) begin
      chk("accept32_timeout", 64'(ir32), 64'd1);
      iv32 = 1'b0;
      return;
    end
    e.x = ex; e.z = ez; e.p = ep;
    q32.push_back(e);
    @(posedge clk);
    #1;
    iv32 = 1'b0;
  endtask

  task automatic idle(input int n);
    iv6 = 1'b0;
    en6 = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((q6.size() != 0 || q32.size() != 0) && n < 100) begin
      n++;
      @(posedge clk);
    end
    #1;
    chk(name, 64'(q6.size() + q32.size()), 64'd0);
  endtask

  initial begin
    int c0;

    // Reset state, sampled while rst is held
    #3;
    chk("rst_out_valid", 64'(ov6), 64'd0);
    chk("rst_x", 64'(x6), 64'd0);
    chk("rst_zp", 64'({z6, p6}), 64'd0);
    chk("rst_in_ready", 64'(ir6), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // XOR cases
    send(6'b101010, 6'b101010, 3'b010, 1'b0, 1'b0, 6'b000000, 1'b1, 1'b0);
    send(6'b111111, 6'b101010, 3'b010, 1'b0, 1'b0, 6'b010101, 1'b0, 1'b1);
    idle(1);
    drain("drain_xor");
    idle(2);

    // Streaming: four ops back-to-back, outputs must occupy cycles c0+2..c0+5
    c0 = cyc;
    send(6'b110100, 6'b010101, 3'b000, 1'b0, 1'b0, 6'b010100, 1'b0, 1'b0);
    send(6'b110100, 6'b010101, 3'b001, 1'b0, 1'b0, 6'b110101, 1'b0, 1'b0);
    send(6'b110100, 6'b010101, 3'b100, 1'b0, 1'b0, 6'b001010, 1'b0, 1'b0);
    send(6'b110100, 6'b010101, 3'b110, 1'b0, 1'b0, 6'b001011, 1'b0, 1'b1);
    idle(6);
    chk("stream_valid_c0", 64'(hist[c0 % 4096]), 64'd0);
    chk("stream_valid_c1", 64'(hist[(c0 + 1) % 4096]), 64'd0);
    for (int i = 2; i < 6; i++) begin
      chk($sformatf("stream_valid_c%0d", i), 64'(hist[(c0 + i) % 4096]), 64'd1);
    end
    chk("stream_valid_c6", 64'(hist[(c0 + 6) % 4096]), 64'd0);
    drain("drain_stream");

    // Backpressure: two accepts fill the pipe, third waits, X holds the first result
    or6 = 1'b0;
    send(6'b111000, 6'b101010, 3'b000, 1'b0, 1'b0, 6'b101000, 1'b0, 1'b0);
    send(6'b000011, 6'b000100, 3'b001, 1'b0, 1'b0, 6'b000111, 1'b0, 1'b1);
    a6 = 6'b111111; b6 = 6'b000000; op6 = 3'b010; iv6 = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("bp_in_ready_low", 64'(ir6), 64'd0);
      chk("bp_x_held", 64'(x6), 64'(6'b101000));
      chk("bp_out_valid", 64'(ov6), 64'd1);
    end
    @(posedge clk);
    #1;
    or6 = 1'b1;
    send(6'b111111, 6'b000000, 3'b010, 1'b0, 1'b0, 6'b111111, 1'b0, 1'b0);
    idle(1);
    drain("drain_backpressure");

    // Accumulate: clear, then XOR acc with 000011 three times
    clr6 = 1'b1;
    @(posedge clk);
    #1;
    clr6 = 1'b0;
    send(6'b111111, 6'b000011, 3'b010, 1'b1, 1'b0, 6'b000011, 1'b0, 1'b0);
    send(6'b111111, 6'b000011, 3'b010, 1'b1, 1'b0, 6'b000000, 1'b1, 1'b0);
    send(6'b111111, 6'b000011, 3'b010, 1'b1, 1'b0, 6'b000011, 1'b0, 1'b0);
    // Clear with accept: this op sees old acc 000011; the next sees acc 0
    send(6'b111111, 6'b000001, 3'b010, 1'b1, 1'b1, 6'b000010, 1'b0, 1'b1);
    send(6'b111111, 6'b000101, 3'b010, 1'b1, 1'b0, 6'b000101, 1'b0, 1'b0);
    idle(1);
    drain("drain_acc");

    // Asynchronous reset with two results in flight
    or6 = 1'b0;
    send(6'b100001, 6'b000000, 3'b111, 1'b0, 1'b0, 6'b100001, 1'b0, 1'b0);
    send(6'b000000, 6'b110011, 3'b110, 1'b0, 1'b0, 6'b111111, 1'b0, 1'b0);
    iv6 = 1'b0;
    #1;
    chk("pre_rst_out_valid", 64'(ov6), 64'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("async_rst_out_valid", 64'(ov6), 64'd0);
    chk("async_rst_x", 64'(x6), 64'd0);
    chk("async_rst_zp", 64'({z6, p6}), 64'd0);
    chk("async_rst_in_ready", 64'(ir6), 64'd1);
    q6.delete();
    @(posedge clk);
    #3;
    rst = 1'b0;
    or6 = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("post_rst_no_stale", 64'(ov6), 64'd0);
    end
    @(posedge clk);
    #1;

    // WIDTH=32
    send32(32'hFFFFFFFF, 32'hFFFFFFFF, 3'b101, 32'hFFFFFFFF, 1'b0, 1'b0);
    send32(32'hFFFFFFFF, 32'hFFFFFFFF, 3'b011, 32'h00000000, 1'b1, 1'b0);
    drain("drain_w32");
    repeat (2) @(posedge clk);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("%0d/%0d checks passed", passed, total + 1);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/logic_alu_pipe.md
Name: logic_alu_pipe

Overview:
- Parametrised-width bitwise logic unit for the ALU datapath; successor to the fixed 6-bit XOR block.
- Supports eight logic ops, an accumulate mode (operand A taken from the last result) and zero/parity flags.
- Two-stage registered pipeline with valid/ready handshakes on input and output, so it sits between the ALU operand issue and the result writeback.

Parameters:
- WIDTH, 6, operand and result width in bits (legal range 1 to 64).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- OP  input  3  op select: 000 AND, 001 OR, 010 XOR, 011 NAND, 100 NOR, 101 XNOR, 110 NOT A, 111 PASS A.
- ACC_EN  input  1  when 1, the accumulator replaces A for this transaction.
- ACC_CLR  input  1  synchronous accumulator clear.
- IN_VALID  input  1  input transaction present.
- IN_READY  output  1  unit can accept this cycle.
- X  output  WIDTH  result.
- Z  output  1  result is all zeros.
- P  output  1  odd parity of result (XOR-reduce of X).
- OUT_VALID  output  1  X/Z/P valid.
- OUT_READY  input  1  downstream accepts the result.

Behaviour:
- Reset: rst high clears both stage valids, the accumulator, X, Z, P and OUT_VALID to 0 immediately, without waiting for clk. In-flight transactions are dropped. IN_READY is 1 while no stage holds data. Reset released mid-stream leaves the pipeline empty.
- Handshakes:
  - An input is accepted on a rising edge with IN_VALID and IN_READY both 1.
  - An output is consumed on a rising edge with OUT_VALID and OUT_READY both 1.
  - The source holds A/B/OP/ACC_EN stable while IN_VALID=1 and IN_READY=0.
- Advance logic (combinational):
  - adv2 = !s2_valid | OUT_READY.
  - adv1 = !s1_valid | adv2.
  - IN_READY = adv1.
  - The OUT_READY to IN_READY combinational path is permitted.
- Stage 1 (on accept):
  - Effective operand EA = ACC_EN ? acc : A.
  - R = OP(EA, B), bitwise, WIDTH bits, no carry or extension.
  - Register R and set s1_valid=1.
  - If adv1=1 with no accept, s1_valid goes to 0.
- Stage 2 (when adv2):
  - X <= s1 result, Z <= (s1 result == 0), P <= ^s1 result, s2_valid <= s1_valid.
  - OUT_VALID = s2_valid.
  - X/Z/P are held unchanged while OUT_VALID=1 and OUT_READY=0.
- Latency and throughput:
  - Latency is 2 cycles from the accept edge to OUT_VALID=1.
  - Throughput is 1 result per cycle with OUT_READY held high.
  - Under backpressure, 2 transactions can be held, then IN_READY=0.
- Accumulator:
  - On every accepted input, acc <= R, whatever the value of ACC_EN.
  - ACC_CLR=1 on an edge sets acc to 0.
  - If ACC_CLR and an accept occur in the same cycle:
    - The accepted op uses the pre-clear acc value.
    - Clear wins: acc ends at 0.
  - Back-to-back ACC_EN transactions see the result of the immediately preceding accepted transaction, with no bubble. The forwarding is inherent because acc updates at stage 1.
- Simultaneous events:
  - Output consume and input accept in the same cycle: both take effect, and the pipeline shifts in one edge.
  - The full pipeline with OUT_READY=1 accepts a new input the same cycle.
- NOT A and PASS A ignore B.
- No state exists beyond the two stage registers and acc.

Test Plan:
- WIDTH=6, OP=XOR:
  - A=101010, B=101010 -> X=000000, Z=1, P=0, two cycles after accept.
  - A=111111, B=101010 -> X=010101, Z=0, P=1.
- WIDTH=6, OUT_READY=1, stream 4 ops back-to-back -> OUT_VALID high for 4 consecutive cycles starting at cycle 2:
  - AND 110100,010101 -> X=010100.
  - OR -> X=110101.
  - NOR -> X=001010.
  - NOT A -> X=001011.
- Backpressure: OUT_READY=0 and send 3 transactions:
  - IN_READY falls after 2 accepts, and X holds the first result.
  - Raise OUT_READY -> results drain in order with no loss or duplication.
- Accumulate:
  - ACC_CLR, then XOR ACC_EN=1 with B=000011, repeated 3 times -> X=000011, 000000, 000011.
  - ACC_CLR plus accept in the same cycle -> that op uses the old acc, and the next ACC_EN op sees acc=0.
- Reset: assert rst asynchronously mid-stream with 2 results in flight -> OUT_VALID, X, Z and P go to 0 before the next edge. After release, no stale result appears.
- WIDTH=32:
  - XNOR with A=B=FFFFFFFF -> X=FFFFFFFF, P=0.
  - NAND with A=B=FFFFFFFF -> X=0, Z=1.
